// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file: grants one of two requesters per cycle
// onto the single write port and tracks which registers still have a result in flight.
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb0_valid,
  input  logic [AW-1:0]   wb0_addr,
  input  logic [XLEN-1:0] wb0_data,
  output logic            wb0_ready,
  input  logic            wb1_valid,
  input  logic [AW-1:0]   wb1_addr,
  input  logic [XLEN-1:0] wb1_data,
  output logic            wb1_ready,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   query_addr_1,
  input  logic [AW-1:0]   query_addr_2,
  output logic            hazard_1,
  output logic            hazard_2,
  output logic [NREGS-1:0] busy,
  output logic [AW-1:0]   rf_write_addr,
  output logic [XLEN-1:0] rf_input_data,
  output logic            rf_enable
);

  logic             prio_q, prio_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic             rf_enable_q, rf_enable_d;
  logic [AW-1:0]    rf_write_addr_q, rf_write_addr_d;
  logic [XLEN-1:0]  rf_input_data_q, rf_input_data_d;

  logic             xfer;
  logic [AW-1:0]    xfer_addr;
  logic [XLEN-1:0]  xfer_data;

  // prio names the port that wins when both request; it only matters on a conflict.
  always_comb begin
    wb0_ready = 1'b0;
    wb1_ready = 1'b0;
    if (!rst) begin
      wb0_ready = wb0_valid && (!wb1_valid || !prio_q);
      wb1_ready = wb1_valid && (!wb0_valid ||  prio_q);
    end
  end

  always_comb begin
    xfer      = wb0_ready || wb1_ready;
    xfer_addr = wb1_ready ? wb1_addr : wb0_addr;
    xfer_data = wb1_ready ? wb1_data : wb0_data;
  end

  always_comb begin
    prio_d = prio_q;
    if (wb0_ready) begin
      prio_d = 1'b1;
    end else if (wb1_ready) begin
      prio_d = 1'b0;
    end
  end

  // Writes to r0 are accepted but never reach the register file.
  always_comb begin
    rf_enable_d     = 1'b0;
    rf_write_addr_d = rf_write_addr_q;
    rf_input_data_d = rf_input_data_q;
    if (xfer && (xfer_addr != '0)) begin
      rf_enable_d     = 1'b1;
      rf_write_addr_d = xfer_addr;
      rf_input_data_d = xfer_data;
    end
  end

  // Per-register scoreboard; an issue on the same edge as a write-back wins
  // because it belongs to a younger instruction.
  assign busy_d[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_busy
      logic set_hit;
      logic clr_hit;
      assign set_hit = issue_valid && (issue_rd == AW'(gi));
      assign clr_hit = xfer && (xfer_addr == AW'(gi));
      assign busy_d[gi] = set_hit || (busy_q[gi] && !clr_hit);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q          <= 1'b0;
      busy_q          <= '0;
      rf_enable_q     <= 1'b0;
      rf_write_addr_q <= '0;
      rf_input_data_q <= '0;
    end else begin
      prio_q          <= prio_d;
      busy_q          <= busy_d;
      rf_enable_q     <= rf_enable_d;
      rf_write_addr_q <= rf_write_addr_d;
      rf_input_data_q <= rf_input_data_d;
    end
  end

  assign busy          = busy_q;
  assign hazard_1      = busy_q[query_addr_1];
  assign hazard_2      = busy_q[query_addr_2];
  assign rf_enable     = rf_enable_q;
  assign rf_write_addr = rf_write_addr_q;
  assign rf_input_data = rf_input_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: grants, write-port latency, scoreboard and reset.
module tb_regfile_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            wb0_valid, wb1_valid, wb0_ready, wb1_ready;
  logic [AW-1:0]   wb0_addr, wb1_addr, issue_rd, query_addr_1, query_addr_2;
  logic [XLEN-1:0] wb0_data, wb1_data;
  logic            issue_valid, hazard_1, hazard_2;
  logic [NREGS-1:0] busy;
  logic [AW-1:0]   rf_write_addr;
  logic [XLEN-1:0] rf_input_data;
  logic            rf_enable;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .query_addr_1(query_addr_1), .query_addr_2(query_addr_2),
    .hazard_1(hazard_1), .hazard_2(hazard_2), .busy(busy),
    .rf_write_addr(rf_write_addr), .rf_input_data(rf_input_data), .rf_enable(rf_enable)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wb0_valid = 1'b1; wb0_addr = 5'd1; wb0_data = 32'h1;
    wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
    issue_valid = 1'b0; issue_rd = '0; query_addr_1 = '0; query_addr_2 = '0;
    #1;
    tick();
    tick();
    checks++; if (wb0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", wb0_ready); end
    checks++; if (rf_enable !== 1'b0) begin errors++; $display("FAIL reset_rf_enable got %b exp 0", rf_enable); end
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy); end
    rst = 1'b0;
    #1;
    checks++; if (wb0_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", wb0_ready); end
    wb0_valid = 1'b0;
    $display("test_reset: ready=%b busy=%h", wb0_ready, busy);
  endtask

  task automatic test_single();
    wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
    #1;
    checks++; if ({wb0_ready, wb1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got %b exp 10", {wb0_ready, wb1_ready}); end
    tick();
    wb0_valid = 1'b0;
    checks++; if ({rf_enable, rf_write_addr, rf_input_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL single_write got en=%b a=%0d d=%h exp en=1 a=5 d=deadbeef", rf_enable, rf_write_addr, rf_input_data);
    end
    tick();
    checks++; if (rf_enable !== 1'b0) begin errors++; $display("FAIL single_idle_en got %b exp 0", rf_enable); end
    checks++; if (rf_write_addr !== 5'd5) begin errors++; $display("FAIL single_hold_addr got %0d exp 5", rf_write_addr); end
    $display("test_single: addr=%0d data=%h", rf_write_addr, rf_input_data);
  endtask

  task automatic test_addr_zero();
    wb1_valid = 1'b1; wb1_addr = 5'd0; wb1_data = 32'h55;
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    checks++; if ({wb0_ready, wb1_ready} !== 2'b01) begin errors++; $display("FAIL zero_ready got %b exp 01", {wb0_ready, wb1_ready}); end
    tick();
    wb1_valid = 1'b0; issue_valid = 1'b0;
    checks++; if (rf_enable !== 1'b0) begin errors++; $display("FAIL zero_rf_enable got %b exp 0", rf_enable); end
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL zero_busy got %h exp 0", busy); end
    $display("test_addr_zero: en=%b busy=%h", rf_enable, busy);
  endtask

  task automatic test_alternate();
    logic [AW-1:0] exp_addr;
    logic [XLEN-1:0] exp_data;
    wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h11;
    wb1_valid = 1'b1; wb1_addr = 5'd4; wb1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i % 2 == 0) begin
        checks++; if ({wb0_ready, wb1_ready} !== 2'b10) begin errors++; $display("FAIL alt_grant%0d got %b exp 10", i, {wb0_ready, wb1_ready}); end
        exp_addr = 5'd3; exp_data = 32'h11;
      end else begin
        checks++; if ({wb0_ready, wb1_ready} !== 2'b01) begin errors++; $display("FAIL alt_grant%0d got %b exp 01", i, {wb0_ready, wb1_ready}); end
        exp_addr = 5'd4; exp_data = 32'h22;
      end
      tick();
      checks++; if ({rf_enable, rf_write_addr, rf_input_data} !== {1'b1, exp_addr, exp_data}) begin
        errors++; $display("FAIL alt_write%0d got en=%b a=%0d d=%h exp en=1 a=%0d d=%h", i, rf_enable, rf_write_addr, rf_input_data, exp_addr, exp_data);
      end
      $display("test_alternate: beat %0d addr=%0d data=%h", i, rf_write_addr, rf_input_data);
    end
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    tick();
  endtask

  task automatic test_hazard();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0; query_addr_1 = 5'd7;
    #1;
    checks++; if (busy[7] !== 1'b1 || hazard_1 !== 1'b1) begin errors++; $display("FAIL hazard_set got busy7=%b hz=%b exp 1 1", busy[7], hazard_1); end
    wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h77;
    #1;
    checks++; if (hazard_1 !== 1'b1) begin errors++; $display("FAIL hazard_before_edge got %b exp 1", hazard_1); end
    tick();
    wb0_valid = 1'b0;
    checks++; if (hazard_1 !== 1'b0) begin errors++; $display("FAIL hazard_clear got %b exp 0", hazard_1); end
    checks++; if ({rf_enable, rf_write_addr} !== {1'b1, 5'd7}) begin errors++; $display("FAIL hazard_write got en=%b a=%0d exp en=1 a=7", rf_enable, rf_write_addr); end
    $display("test_hazard: hazard_1=%b busy=%h", hazard_1, busy);
  endtask

  task automatic test_set_wins();
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    query_addr_2 = 5'd9;
    wb1_valid = 1'b1; wb1_addr = 5'd9; wb1_data = 32'h99;
    #1;
    checks++; if (hazard_2 !== 1'b1) begin errors++; $display("FAIL setwins_pre got %b exp 1", hazard_2); end
    checks++; if (wb1_ready !== 1'b1) begin errors++; $display("FAIL setwins_ready got %b exp 1", wb1_ready); end
    tick();
    issue_valid = 1'b0; wb1_valid = 1'b0;
    checks++; if (busy !== 32'h0000_0200) begin errors++; $display("FAIL setwins_busy got %h exp 00000200", busy); end
    checks++; if ({rf_enable, rf_write_addr, rf_input_data} !== {1'b1, 5'd9, 32'h99}) begin
      errors++; $display("FAIL setwins_write got en=%b a=%0d d=%h exp en=1 a=9 d=99", rf_enable, rf_write_addr, rf_input_data);
    end
    $display("test_set_wins: busy=%h addr=%0d", busy, rf_write_addr);
  endtask

  task automatic test_reset_mid();
    // Fill busy up to 0x0F00 (bit 9 is already pending)
    for (int r = 8; r < 12; r++) begin
      issue_valid = 1'b1; issue_rd = AW'(r);
      tick();
    end
    issue_valid = 1'b0;
    checks++; if (busy !== 32'h0000_0F00) begin errors++; $display("FAIL mid_busy_fill got %h exp 00000f00", busy); end
    wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'haa;
    wb1_valid = 1'b1; wb1_addr = 5'd4; wb1_data = 32'hbb;
    rst = 1'b1;
    #1;
    checks++; if ({wb0_ready, wb1_ready} !== 2'b00) begin errors++; $display("FAIL mid_ready_in_rst got %b exp 00", {wb0_ready, wb1_ready}); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL mid_busy got %h exp 0", busy); end
    checks++; if (rf_enable !== 1'b0) begin errors++; $display("FAIL mid_rf_enable got %b exp 0", rf_enable); end
    checks++; if ({wb0_ready, wb1_ready} !== 2'b10) begin errors++; $display("FAIL mid_first_grant got %b exp 10", {wb0_ready, wb1_ready}); end
    tick();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    checks++; if ({rf_enable, rf_write_addr} !== {1'b1, 5'd3}) begin errors++; $display("FAIL mid_write got en=%b a=%0d exp en=1 a=3", rf_enable, rf_write_addr); end
    $display("test_reset_mid: busy=%h addr=%0d", busy, rf_write_addr);
  endtask

  initial begin
    test_reset();
    test_single();
    test_addr_zero();
    test_alternate();
    test_hazard();
    test_set_wins();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
